// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate among NUM_REQ managers, one transaction at a time.
// Optional response watchdog enabled by defining OBI_ARB_TIMEOUT_EN.
module obi_rr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      m_req_i,
    input  logic [NUM_REQ*AW-1:0]   m_addr_i,
    input  logic [NUM_REQ-1:0]      m_we_i,
    input  logic [NUM_REQ*DW/8-1:0] m_be_i,
    input  logic [NUM_REQ*DW-1:0]   m_wdata_i,
    output logic [NUM_REQ-1:0]      m_gnt_o,
    output logic [NUM_REQ-1:0]      m_rvalid_o,
    output logic [DW-1:0]           m_rdata_o,
    output logic                    m_err_o,
    output logic                    s_req_o,
    output logic [AW-1:0]           s_addr_o,
    output logic                    s_we_o,
    output logic [DW/8-1:0]         s_be_o,
    output logic [DW-1:0]           s_wdata_o,
    input  logic                    s_gnt_i,
    input  logic                    s_rvalid_i,
    input  logic [DW-1:0]           s_rdata_i,
    input  logic                    s_err_i,
    output logic                    busy_o,
    output logic                    timeout_o
);
    localparam int SELW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_RESP = 2'd2} state_t;

    state_t            r_state, w_state_nxt;
    logic [SELW-1:0]   r_sel, w_sel_nxt;
    logic [SELW-1:0]   r_last, w_last_nxt;
    logic [SELW-1:0]   w_winner;
    logic              w_expire;

`ifdef OBI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    // Watchdog: counts completed RESP cycles; held at zero outside RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state != ST_RESP) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    // Cyclic priority scan starting after r_last; the nearest requester is assigned last and wins.
    always_comb begin
        w_winner = r_last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (m_req_i[(int'(r_last) + k) % NUM_REQ]) begin
                w_winner = SELW'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_last  <= SELW'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic and same-cycle routing of request and response paths.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        m_gnt_o     = '0;
        m_rvalid_o  = '0;
        m_rdata_o   = '0;
        m_err_o     = 1'b0;
        s_req_o     = 1'b0;
        s_addr_o    = '0;
        s_we_o      = 1'b0;
        s_be_o      = '0;
        s_wdata_o   = '0;
        timeout_o   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|m_req_i) begin
                    w_sel_nxt   = w_winner;
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                s_req_o   = m_req_i[r_sel];
                s_addr_o  = m_addr_i[r_sel*AW +: AW];
                s_we_o    = m_we_i[r_sel];
                s_be_o    = m_be_i[r_sel*(DW/8) +: DW/8];
                s_wdata_o = m_wdata_i[r_sel*DW +: DW];
                m_gnt_o[r_sel] = s_gnt_i & m_req_i[r_sel];
                if (s_gnt_i && m_req_i[r_sel]) begin
                    w_state_nxt = ST_RESP;
                end else if (!m_req_i[r_sel]) begin
                    // Request withdrawn before grant: abandon without moving the pointer.
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_RESP: begin
                if (s_rvalid_i) begin
                    m_rvalid_o[r_sel] = 1'b1;
                    m_rdata_o   = s_rdata_i;
                    m_err_o     = s_err_i;
                    w_last_nxt  = r_sel;
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    m_rvalid_o[r_sel] = 1'b1;
                    m_rdata_o   = DW'(TIMEOUT_DATA);
                    m_err_o     = 1'b1;
                    timeout_o   = 1'b1;
                    w_last_nxt  = r_sel;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: transaction-level reference model with randomized traffic.
// Define OBI_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_obi_rr_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;
`ifdef OBI_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req_i;
    logic [N*AW-1:0] m_addr_i;
    logic [N-1:0]    m_we_i;
    logic [N*BW-1:0] m_be_i;
    logic [N*DW-1:0] m_wdata_i;
    logic [N-1:0]    m_gnt_o, m_rvalid_o;
    logic [DW-1:0]   m_rdata_o;
    logic            m_err_o, s_req_o, s_we_o, s_gnt_i, s_rvalid_i, s_err_i, busy_o, timeout_o;
    logic [AW-1:0]   s_addr_o;
    logic [BW-1:0]   s_be_o;
    logic [DW-1:0]   s_wdata_o, s_rdata_i;

    logic [AW-1:0] a_addr  [N];
    logic          a_we    [N];
    logic [BW-1:0] a_be    [N];
    logic [DW-1:0] a_wdata [N];

    int total = 0;
    int bad   = 0;
    int last_m = N - 1;
    int busy_cnt;
    logic [N-1:0] got_gnt;

    always #5 clk = ~clk;

    obi_rr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first requesting index after 'last', wrapping around.
    function automatic int rr_pick(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_req(input logic [N-1:0] mask);
        m_req_i = mask;
        for (int k = 0; k < N; k++) begin
            m_addr_i[k*AW +: AW]  = a_addr[k];
            m_we_i[k]             = a_we[k];
            m_be_i[k*BW +: BW]    = a_be[k];
            m_wdata_i[k*DW +: DW] = a_wdata[k];
        end
    endtask

    task automatic rand_fields();
        for (int k = 0; k < N; k++) begin
            a_addr[k]  = $urandom;
            a_we[k]    = 1'($urandom_range(0, 1));
            a_be[k]    = BW'($urandom);
            a_wdata[k] = $urandom;
        end
    endtask

    task automatic quiet(input string tag, input logic exp_busy);
        chk({tag, "_gnt"}, 64'(m_gnt_o), 64'd0);
        chk({tag, "_rvalid"}, 64'(m_rvalid_o), 64'd0);
        chk({tag, "_rdata"}, 64'(m_rdata_o), 64'd0);
        chk({tag, "_err"}, 64'(m_err_o), 64'd0);
        chk({tag, "_sreq"}, 64'(s_req_o), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'(exp_busy));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: IDLE arbitration, gd wait cycles before grant, rd cycles before rvalid.
    task automatic do_txn(input logic [N-1:0] mask, input int gd, input int rd,
                          input bit spur, input logic [DW-1:0] rdat, input logic rerr);
        int w;
        logic [N-1:0] onehot;
        bit expired;
        w = rr_pick(last_m, mask);
        onehot = N'(1) << w;
        busy_cnt = 0;
        expired = 1'b0;
        drive_req(mask);
        s_gnt_i = spur;
        s_rvalid_i = spur;
        @(negedge clk);
        quiet("idle", 1'b0);
        next_cycle();
        s_rvalid_i = 1'b0;
        for (int i = 0; i < gd; i++) begin
            s_gnt_i = 1'b0;
            s_rvalid_i = spur;
            @(negedge clk);
            busy_cnt += int'(busy_o);
            chk("addr_wait_sreq", 64'(s_req_o), 64'd1);
            chk("addr_wait_saddr", 64'(s_addr_o), 64'(a_addr[w]));
            chk("addr_wait_gnt", 64'(m_gnt_o), 64'd0);
            chk("addr_wait_rvalid", 64'(m_rvalid_o), 64'd0);
            next_cycle();
        end
        s_gnt_i = 1'b1;
        s_rvalid_i = 1'b0;
        @(negedge clk);
        busy_cnt += int'(busy_o);
        got_gnt = m_gnt_o;
        chk("gnt", 64'(m_gnt_o), 64'(onehot));
        chk("saddr", 64'(s_addr_o), 64'(a_addr[w]));
        chk("swe", 64'(s_we_o), 64'(a_we[w]));
        chk("sbe", 64'(s_be_o), 64'(a_be[w]));
        chk("swdata", 64'(s_wdata_o), 64'(a_wdata[w]));
        next_cycle();
        s_gnt_i = spur;
        for (int i = 0; i <= rd && !expired; i++) begin
            s_rvalid_i = (i == rd);
            s_rdata_i = (i == rd) ? rdat : DW'($urandom);
            s_err_i = (i == rd) ? rerr : 1'($urandom_range(0, 1));
            @(negedge clk);
            busy_cnt += int'(busy_o);
            chk("resp_gnt", 64'(m_gnt_o), 64'd0);
            chk("resp_sreq", 64'(s_req_o), 64'd0);
            if (i == rd) begin
                chk("rvalid", 64'(m_rvalid_o), 64'(onehot));
                chk("rdata", 64'(m_rdata_o), 64'(rdat));
                chk("err", 64'(m_err_o), 64'(rerr));
                chk("resp_timeout", 64'(timeout_o), 64'd0);
            end else if (TO_EN && i == TO - 1) begin
                expired = 1'b1;
                chk("to_rvalid", 64'(m_rvalid_o), 64'(onehot));
                chk("to_rdata", 64'(m_rdata_o), 64'(32'hDEAD_BEEF));
                chk("to_err", 64'(m_err_o), 64'd1);
                chk("to_pulse", 64'(timeout_o), 64'd1);
            end else begin
                chk("wait_rvalid", 64'(m_rvalid_o), 64'd0);
                chk("wait_rdata", 64'(m_rdata_o), 64'd0);
                chk("wait_timeout", 64'(timeout_o), 64'd0);
            end
            next_cycle();
        end
        s_rvalid_i = 1'b0;
        s_gnt_i = 1'b0;
        last_m = w;
    endtask

    initial begin
        rst = 1'b1;
        m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0; s_err_i = 1'b0;
        rand_fields();
        #2;
        quiet("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // Single manager 0 write, immediate grant, rvalid two cycles after grant.
        a_addr[0] = 32'h0000_0010; a_wdata[0] = 32'h1234_5678; a_we[0] = 1'b1; a_be[0] = 4'hF;
        do_txn(2'b01, 0, 2, 1'b0, 32'h0, 1'b0);
        chk("busy_cycles", 64'(busy_cnt), 64'd4);

        // Both managers requesting continuously: strict alternation.
        for (int t = 0; t < 6; t++) begin
            rand_fields();
            do_txn(2'b11, 0, 0, 1'b0, DW'($urandom), 1'b0);
            chk("rr_order", 64'(got_gnt), 64'(N'(1) << ((t + 1) % N)));
        end

        // Manager 1 read with error response.
        rand_fields();
        a_we[1] = 1'b0;
        do_txn(2'b10, 1, 1, 1'b0, 32'hCAFE_F00D, 1'b1);

        // Spurious rvalid and held gnt with nobody requesting.
        drive_req(2'b00);
        s_gnt_i = 1'b1;
        s_rvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            quiet("spurious_idle", 1'b0);
            next_cycle();
        end
        s_gnt_i = 1'b0;
        s_rvalid_i = 1'b0;

        // Request withdrawn before grant: back to IDLE, pointer unchanged.
        rand_fields();
        drive_req(2'b11);
        @(negedge clk);
        next_cycle();
        drive_req(2'b00);
        @(negedge clk);
        chk("drop_sreq", 64'(s_req_o), 64'd0);
        chk("drop_gnt", 64'(m_gnt_o), 64'd0);
        chk("drop_busy", 64'(busy_o), 64'd1);
        next_cycle();
        @(negedge clk);
        quiet("drop_idle", 1'b0);
        next_cycle();
        do_txn(2'b11, 0, 0, 1'b0, DW'($urandom), 1'b0);

        // Reset while in RESP, then a late rvalid.
        rand_fields();
        drive_req(2'b11);
        @(negedge clk);
        next_cycle();
        s_gnt_i = 1'b1;
        @(negedge clk);
        chk("pre_rst_gnt", 64'(m_gnt_o), 64'(N'(1) << rr_pick(last_m, 2'b11)));
        next_cycle();
        s_gnt_i = 1'b0;
        rst = 1'b1;
        #1;
        quiet("rst_mid", 1'b0);
        drive_req(2'b00);
        s_rvalid_i = 1'b1;
        s_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        rst = 1'b0;
        last_m = N - 1;
        next_cycle();
        @(negedge clk);
        quiet("late_rvalid", 1'b0);
        next_cycle();
        s_rvalid_i = 1'b0;
        rand_fields();
        do_txn(2'b11, 0, 1, 1'b0, DW'($urandom), 1'b0);
        chk("post_rst_first", 64'(got_gnt), 64'd1);

        if (TO_EN) begin
            // Subordinate never answers, then a late rvalid, then an answer on the final cycle.
            rand_fields();
            do_txn(2'b01, 0, 3 * TO, 1'b0, 32'h0, 1'b0);
            do_txn(2'b10, 0, 0, 1'b1, DW'($urandom), 1'b0);
            do_txn(2'b01, 1, TO - 1, 1'b0, 32'h0BAD_F00D, 1'b0);
        end

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            rand_fields();
            do_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                   DW'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI subordinate port (the OBI-to-APB bridge feeding the student domain) between NUM_REQ OBI managers, e.g. SysCtrl core and a debug/loader master.
- Round-robin arbitration, one outstanding transaction at a time; the APB side serialises accesses anyway.
- Routes gnt/rvalid/rdata/err back to the owning manager.
- Sits between the SysCtrl OBI outputs and the bridge input in the simulation top and the SoC interconnect.

Parameters:
- NUM_REQ, 2, number of OBI managers (2..8).
- AW, 32, OBI address width.
- DW, 32, OBI data width.
- TIMEOUT_CYCLES, 256, response watchdog limit; used only with OBI_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- m_req_i  in  NUM_REQ  per-manager request
- m_addr_i  in  NUM_REQ*AW  per-manager address, manager k at bits [k*AW +: AW]
- m_we_i  in  NUM_REQ  per-manager write enable
- m_be_i  in  NUM_REQ*DW/8  per-manager byte enables
- m_wdata_i  in  NUM_REQ*DW  per-manager write data
- m_gnt_o  out  NUM_REQ  per-manager grant
- m_rvalid_o  out  NUM_REQ  per-manager response valid
- m_rdata_o  out  DW  response data, shared; qualified by m_rvalid_o
- m_err_o  out  1  response error, shared; qualified by m_rvalid_o
- s_req_o  out  1  subordinate request
- s_addr_o  out  AW  subordinate address
- s_we_o  out  1  subordinate write enable
- s_be_o  out  DW/8  subordinate byte enables
- s_wdata_o  out  DW  subordinate write data
- s_gnt_i  in  1  subordinate grant
- s_rvalid_i  in  1  subordinate response valid
- s_rdata_i  in  DW  subordinate read data
- s_err_i  in  1  subordinate error
- busy_o  out  1  high whenever state is not IDLE
- timeout_o  out  1  one-cycle pulse on watchdog expiry; tied 0 without the macro

Behaviour:
- Clock and reset: one clock clk_i; rst_i is asynchronous and active-high.
- Reset values:
  - state=IDLE, sel_q=0, last_q=NUM_REQ-1, so manager 0 wins the first arbitration.
  - All outputs 0.
  - Reset mid-transaction abandons it; no gnt/rvalid is emitted for it.
- State machine IDLE / ADDR / RESP:
  - IDLE:
    - If any m_req_i bit is set, pick the first set index scanning cyclically from last_q+1.
    - sel_q<=winner; go to ADDR. Arbitration latency is 1 cycle.
    - No outputs asserted in IDLE.
  - ADDR:
    - s_req_o = m_req_i[sel_q].
    - s_addr/we/be/wdata are combinationally muxed from manager sel_q.
    - m_gnt_o[sel_q] = s_gnt_i & m_req_i[sel_q], same cycle.
    - On that handshake, go to RESP.
    - If m_req_i[sel_q] drops without grant (protocol violation), return to IDLE without updating last_q.
  - RESP:
    - s_req_o=0; all m_gnt_o=0.
    - On s_rvalid_i: m_rvalid_o[sel_q]=1, m_rdata_o=s_rdata_i, m_err_o=s_err_i, all combinational same cycle.
    - Then last_q<=sel_q and go to IDLE.
- Response and data rules:
  - Managers are always ready to accept responses; there is no rready.
  - Response latency added by the arbiter is 0.
  - Total occupancy per transaction is 1 (arbitration) + grant wait + response wait cycles.
- Throughput: back-to-back requests from one manager get at most one grant per 2 cycles plus subordinate latency, because of the IDLE cycle between transactions.
- Fairness: with all managers continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0; no manager waits more than NUM_REQ-1 transactions.
- Boundary and illegal cases:
  - s_rvalid_i in IDLE or ADDR is ignored (spurious); nothing is forwarded.
  - s_gnt_i in IDLE or RESP is ignored.
  - A manager raising m_req_i while another transaction is in flight is held off (m_gnt_o=0) until arbitration.
  - When m_rvalid_o is 0, m_rdata_o and m_err_o drive 0.
  - Single requester: always wins, independent of last_q.

Optional Feature:
- Macro: OBI_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to RESP and increments each RESP cycle.
  - If it reaches TIMEOUT_CYCLES without s_rvalid_i, assert m_rvalid_o[sel_q]=1, m_err_o=1, m_rdata_o=32'hDEAD_BEEF (DW-truncated), and pulse timeout_o.
  - Then set last_q<=sel_q and go to IDLE.
  - A late s_rvalid_i is then dropped per the spurious rule.
  - s_rvalid_i in the same cycle as expiry wins: normal response, no timeout_o.
- Without the macro: no counter; RESP waits indefinitely; timeout_o tied 0.

Test Plan:
- Single manager 0 writes addr 0x0000_0010, wdata 0x1234_5678, subordinate gnt immediately, rvalid 2 cycles later -> s_addr_o=0x10 during ADDR; m_gnt_o=01 one cycle; m_rvalid_o=01 with err=0; busy_o high for 4 cycles.
- Managers 0 and 1 request continuously for 6 transactions -> grant order 0,1,0,1,0,1; m_gnt_o never has 2 bits set.
- Manager 1 read, subordinate returns rdata 0xCAFE_F00D, err=1 -> m_rvalid_o=10, m_rdata_o=0xCAFE_F00D, m_err_o=1; manager 0 sees nothing.
- Spurious s_rvalid_i pulse in IDLE, and s_gnt_i held high in IDLE -> no m_rvalid_o/m_gnt_o activity; state stays IDLE.
- rst_i asserted in RESP, then a late s_rvalid_i -> all outputs 0 immediately; next arbitration with both requesting grants manager 0 first.
- With OBI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, subordinate never responds -> after 8 RESP cycles m_rvalid_o[sel]=1, m_err_o=1, m_rdata_o=0xDEADBEEF, timeout_o pulses once; rerun with rvalid on cycle 8 -> normal response, no timeout_o.
